// File: rtl/mul_seq_pkg.sv
// mul_seq_pkg: shared types and constants for the Acc/MQ/DR command sequencer.
//   state_e            sequencer FSM states
//   cmd_t              latched command (opcode + two operands)
//   result_t           16-bit {Acc, MQ} result
//   DEF_TIMEOUT_CYCLES default EXEC wait limit used when MUL_SEQ_TIMEOUT_EN is defined
package mul_seq_pkg;

  localparam int unsigned DEF_TIMEOUT_CYCLES = 64;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LD_DR   = 3'd1,
    LD_MQ   = 3'd2,
    CLR_ACC = 3'd3,
    EXEC    = 3'd4,
    RD_ACC  = 3'd5,
    RD_MQ   = 3'd6,
    RESP    = 3'd7
  } state_e;

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } cmd_t;

  typedef logic [15:0] result_t;

endpackage

// File: rtl/mul_seq_watchdog.sv
// mul_seq_watchdog: EXEC-phase wait counter.
//   clock, reset_n  clock / synchronous active-low reset
//   clear           zero the count (held while outside EXEC)
//   enable          count this cycle (high during EXEC)
//   limit           number of counted cycles allowed
//   expired         the current enabled cycle is the limit-th one, i.e. the
//                   count reaches limit at the coming edge
module mul_seq_watchdog #(
  parameter int unsigned TW = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          enable,
  input  logic [TW-1:0] limit,
  output logic          expired
);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)       cnt_d = '0;
    else if (enable) cnt_d = cnt_q + TW'(1);
  end

  // Compare against limit-1 so the sequencer leaves EXEC on the same edge
  // that the count would reach limit.
  assign expired = enable && (cnt_q == (limit - TW'(1)));

  always_ff @(posedge clock) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mul_bus_sequencer.sv
// mul_bus_sequencer: command front end for the 8-bit Acc/MQ/DR datapath.
// Accepts {op, a, b} on cmd_*, loads DR/MQ/clears Acc over inBUS, drives INS
// until RDY, reads Acc then MQ over outBUS and returns {Acc, MQ} on rsp_*.
//   clock, reset_n       clock / synchronous active-low reset
//   cmd_valid/ready      command handshake; cmd_op, cmd_a, cmd_b payload
//   rsp_valid/ready      response handshake; rsp_data {Acc,MQ}, rsp_err timeout
//   INS, LD*, ST*, inBUS datapath controls (registered, decoded from state)
//   outBUS, RDY          datapath read bus and ready
//   TESTMODE             tied 0
// Build option: MUL_SEQ_TIMEOUT_EN adds an EXEC watchdog (TIMEOUT_CYCLES, TW);
// without it EXEC waits for RDY indefinitely and rsp_err is tied 0.
module mul_bus_sequencer
  import mul_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned TW             = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic [2:0]  INS,
  output logic        LDAcc,
  output logic        LDMQ,
  output logic        LDDR,
  output logic        STAcc,
  output logic        STMQ,
  output logic        STDR,
  output logic        TESTMODE,
  output logic [7:0]  inBUS,
  input  logic [7:0]  outBUS,
  input  logic        RDY
);

  state_e  state_q, state_d;
  cmd_t    cmd_q, cmd_d;
  result_t rsp_data_q, rsp_data_d;
  logic    exec_first_q, exec_first_d;
  logic    cmd_ready_q, cmd_ready_d;
  logic    rsp_valid_q, rsp_valid_d;
  logic [2:0] ins_q, ins_d;
  logic    ld_acc_q, ld_acc_d, ld_mq_q, ld_mq_d, ld_dr_q, ld_dr_d;
  logic    st_acc_q, st_acc_d, st_mq_q, st_mq_d;
  logic [7:0] inbus_q, inbus_d;
  logic    rdy_qual;

  // RDY in the first EXEC cycle still reflects the previous operation.
  assign rdy_qual = (state_q == EXEC) && !exec_first_q && RDY;

`ifdef MUL_SEQ_TIMEOUT_EN
  localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYCLES);
  logic rsp_err_q, rsp_err_d, wd_expired;

  mul_seq_watchdog #(.TW(TW)) u_wd (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (state_q != EXEC),
    .enable  (state_q == EXEC),
    .limit   (LIMIT),
    .expired (wd_expired)
  );
`endif

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    rsp_data_d = rsp_data_q;
`ifdef MUL_SEQ_TIMEOUT_EN
    rsp_err_d  = rsp_err_q;
`endif
    case (state_q)
      IDLE: begin
        // cmd_ready_q gates acceptance so nothing is taken in the first
        // cycle after reset release.
        if (cmd_valid && cmd_ready_q) begin
          cmd_d   = '{op: cmd_op, a: cmd_a, b: cmd_b};
          state_d = LD_DR;
`ifdef MUL_SEQ_TIMEOUT_EN
          rsp_err_d = 1'b0;
`endif
        end
      end
      LD_DR:   state_d = LD_MQ;
      LD_MQ:   state_d = CLR_ACC;
      CLR_ACC: state_d = EXEC;
      EXEC: begin
        // A qualified RDY beats a simultaneous timeout.
        if (rdy_qual) state_d = RD_ACC;
`ifdef MUL_SEQ_TIMEOUT_EN
        else if (wd_expired) begin
          state_d    = RESP;
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
        end
`endif
      end
      RD_ACC: begin
        rsp_data_d[15:8] = outBUS;
        state_d          = RD_MQ;
      end
      RD_MQ: begin
        rsp_data_d[7:0] = outBUS;
        state_d         = RESP;
      end
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state and registered, so they are
    // valid for the whole cycle the FSM spends in that state.
    cmd_ready_d  = (state_d == IDLE);
    rsp_valid_d  = (state_d == RESP);
    ld_dr_d      = (state_d == LD_DR);
    ld_mq_d      = (state_d == LD_MQ);
    ld_acc_d     = (state_d == CLR_ACC);
    st_acc_d     = (state_d == RD_ACC);
    st_mq_d      = (state_d == RD_MQ);
    ins_d        = (state_d == EXEC) ? cmd_d.op : 3'b000;
    inbus_d      = (state_d == LD_DR) ? cmd_d.a :
                   (state_d == LD_MQ) ? cmd_d.b : 8'h00;
    exec_first_d = (state_d == EXEC) && (state_q != EXEC);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cmd_q        <= '0;
      rsp_data_q   <= '0;
      exec_first_q <= 1'b0;
      cmd_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      ins_q        <= '0;
      ld_acc_q     <= 1'b0;
      ld_mq_q      <= 1'b0;
      ld_dr_q      <= 1'b0;
      st_acc_q     <= 1'b0;
      st_mq_q      <= 1'b0;
      inbus_q      <= '0;
`ifdef MUL_SEQ_TIMEOUT_EN
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      rsp_data_q   <= rsp_data_d;
      exec_first_q <= exec_first_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      ins_q        <= ins_d;
      ld_acc_q     <= ld_acc_d;
      ld_mq_q      <= ld_mq_d;
      ld_dr_q      <= ld_dr_d;
      st_acc_q     <= st_acc_d;
      st_mq_q      <= st_mq_d;
      inbus_q      <= inbus_d;
`ifdef MUL_SEQ_TIMEOUT_EN
      rsp_err_q    <= rsp_err_d;
`endif
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign INS       = ins_q;
  assign LDAcc     = ld_acc_q;
  assign LDMQ      = ld_mq_q;
  assign LDDR      = ld_dr_q;
  assign STAcc     = st_acc_q;
  assign STMQ      = st_mq_q;
  assign STDR      = 1'b0;
  assign TESTMODE  = 1'b0;
  assign inBUS     = inbus_q;
`ifdef MUL_SEQ_TIMEOUT_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mul_bus_sequencer.sv
// Bench for mul_bus_sequencer: table of commands with a scoreboard of
// expected {Acc, MQ} results, plus reset, backpressure and timeout sequences.
module tb_mul_bus_sequencer;

  localparam int TO = 8;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [2:0]  cmd_op = '0;
  logic [7:0]  cmd_a = '0, cmd_b = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [15:0] rsp_data;
  logic [2:0]  INS;
  logic        LDAcc, LDMQ, LDDR, STAcc, STMQ, STDR, TESTMODE;
  logic [7:0]  inBUS, outBUS;
  logic        RDY = 1'b0;

  always #5 clock = ~clock;

  mul_bus_sequencer #(.TIMEOUT_CYCLES(TO), .TW(8)) dut (
    .clock(clock), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err),
    .INS(INS), .LDAcc(LDAcc), .LDMQ(LDMQ), .LDDR(LDDR),
    .STAcc(STAcc), .STMQ(STMQ), .STDR(STDR), .TESTMODE(TESTMODE),
    .inBUS(inBUS), .outBUS(outBUS), .RDY(RDY)
  );

  // Datapath read-back model: Acc / MQ values presented on their store strobe.
  logic [7:0] cur_acc = '0, cur_mq = '0;
  assign outBUS = STAcc ? cur_acc : (STMQ ? cur_mq : 8'h00);

  int n_chk = 0, n_pass = 0;
  logic [15:0] sb_q[$];

  typedef struct {
    logic [2:0] op;
    logic [7:0] a, b;
    int         rdy_at;   // EXEC cycle from which RDY is high
    logic [7:0] acc, mq;  // datapath values returned
    int         bp;       // cycles of rsp_ready backpressure
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Store-strobe invariants hold on every cycle.
  always @(negedge clock) begin
    check("st_onehot", 32'(STAcc & STMQ), 0);
    check("stdr_zero", 32'(STDR), 0);
    check("testmode_zero", 32'(TESTMODE), 0);
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 32'({cmd_ready, rsp_valid, rsp_err, LDAcc, LDMQ, LDDR, STAcc, STMQ}), 0);
    check({tag, "_ins"}, 32'(INS), 0);
    check({tag, "_inbus"}, 32'(inBUS), 0);
    check({tag, "_rsp_data"}, 32'(rsp_data), 0);
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input int rdy_at, input logic [7:0] acc, input logic [7:0] mq,
                         input int bp, input bit to);
    int L, w;
    logic [15:0] exp_d;
    L = to ? TO : (rdy_at < 2 ? 2 : rdy_at);
    w = 0;
    while (!cmd_ready && w < 30) begin @(negedge clock); w++; end
    check("cmd_ready_wait", 32'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    cur_acc = acc; cur_mq = mq;
    RDY = !to && (rdy_at <= 1);
    sb_q.push_back(to ? 16'h0000 : {acc, mq});
    @(negedge clock);  // T+1
    cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    check("ld_dr", 32'({LDDR, LDMQ, LDAcc, cmd_ready}), 32'h8);
    check("inbus_a", 32'(inBUS), 32'(a));
    @(negedge clock);  // T+2
    check("ld_mq", 32'({LDDR, LDMQ, LDAcc, cmd_ready}), 32'h4);
    check("inbus_b", 32'(inBUS), 32'(b));
    @(negedge clock);  // T+3
    check("ld_acc", 32'({LDDR, LDMQ, LDAcc, cmd_ready}), 32'h2);
    check("inbus_zero", 32'(inBUS), 0);
    for (int k = 1; k <= L; k++) begin
      @(negedge clock);
      check("exec_ins", 32'(INS), 32'(op));
      check("exec_quiet", 32'({STAcc, STMQ, rsp_valid, LDAcc | LDMQ | LDDR}), 0);
      RDY = !to && (k >= rdy_at);
    end
    if (!to) begin
      @(negedge clock);
      RDY = 1'b0;
      check("rd_acc", 32'({STAcc, STMQ, rsp_valid}), 32'h4);
      @(negedge clock);
      check("rd_mq", 32'({STAcc, STMQ, rsp_valid}), 32'h2);
    end
    @(negedge clock);
    check("rsp_valid", 32'(rsp_valid), 1);
    exp_d = (sb_q.size() > 0) ? sb_q.pop_front() : 16'hxxxx;
    check("rsp_data", 32'(rsp_data), 32'(exp_d));
    check("rsp_err", 32'(rsp_err), 32'(to));
    check("rsp_busy", 32'({cmd_ready, STAcc, STMQ}), 0);
    if (bp > 0) begin
      // A command offered while busy must not be consumed.
      cmd_valid = 1'b1; cmd_op = 3'h7; cmd_a = 8'hEE; cmd_b = 8'hDD;
      for (int i = 0; i < bp; i++) begin
        @(negedge clock);
        check("bp_valid", 32'(rsp_valid), 1);
        check("bp_data", 32'(rsp_data), 32'(exp_d));
        check("bp_busy", 32'({cmd_ready, LDDR}), 0);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    check("post_hs", 32'({rsp_valid, cmd_ready, LDDR}), 32'h2);
    cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{op: 3'b101, a: 8'h05, b: 8'h03, rdy_at: 3, acc: 8'h00, mq: 8'h0F, bp: 0};
    vecs[1] = '{op: 3'b001, a: 8'hAA, b: 8'h55, rdy_at: 1, acc: 8'h12, mq: 8'h34, bp: 0};
    vecs[2] = '{op: 3'b111, a: 8'hFF, b: 8'hFF, rdy_at: 5, acc: 8'hFE, mq: 8'h01, bp: 5};
    vecs[3] = '{op: 3'b000, a: 8'h00, b: 8'h00, rdy_at: 2, acc: 8'h80, mq: 8'h7F, bp: 0};
    vecs[4] = '{op: 3'b010, a: 8'h01, b: 8'h80, rdy_at: 1, acc: 8'hFF, mq: 8'hFF, bp: 2};

    // Reset state
    repeat (2) @(negedge clock);
    check_all_zero("reset");
    reset_n = 1'b1;
    check("ready_before_edge", 32'(cmd_ready), 0);
    @(negedge clock);
    check("ready_after_release", 32'(cmd_ready), 1);

    foreach (vecs[i])
      run_cmd(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rdy_at,
              vecs[i].acc, vecs[i].mq, vecs[i].bp, 1'b0);

    // Reset during EXEC discards the command.
    cmd_valid = 1'b1; cmd_op = 3'b011; cmd_a = 8'h12; cmd_b = 8'h34; RDY = 1'b0;
    @(negedge clock);
    cmd_valid = 1'b0;
    check("mid_ld_dr", 32'(LDDR), 1);
    repeat (4) @(negedge clock);
    check("mid_exec_ins", 32'(INS), 32'h3);
    reset_n = 1'b0; RDY = 1'b1;
    @(negedge clock);
    check_all_zero("mid_rst");
    reset_n = 1'b1;
    @(negedge clock);
    check("mid_rst_ready", 32'(cmd_ready), 1);
    begin
      int seen = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clock);
        if (rsp_valid || STAcc || STMQ) seen++;
      end
      check("mid_rst_no_rsp", 32'(seen), 0);
    end
    RDY = 1'b0;

    // Sequencer still works after the mid-operation reset.
    run_cmd(3'b100, 8'h3C, 8'hC3, 2, 8'h5A, 8'hA5, 0, 1'b0);

`ifdef MUL_SEQ_TIMEOUT_EN
    run_cmd(3'b110, 8'h07, 8'h09, 0, 8'hAA, 8'hBB, 0, 1'b1);
    run_cmd(3'b011, 8'h02, 8'h04, TO, 8'h11, 8'h22, 0, 1'b0);
`endif

    check("scoreboard_empty", 32'(sb_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mul_bus_sequencer.md
# mul_bus_sequencer

Command-level front end for the 8-bit Acc/MQ/DR arithmetic datapath. It accepts one operation (opcode plus two 8-bit operands) over a valid/ready handshake and drives the datapath's load strobes, `inBUS` and `INS` in a fixed sequence. It waits for `RDY`, then reads Acc and MQ back over `outBUS` and returns a 16-bit result over a second valid/ready handshake. It sits directly upstream of the datapath and is the only agent driving its control inputs.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 64: maximum EXEC cycles spent waiting for `RDY` (range 2..255).
- `TW`, default 8: watchdog counter width.

Ports:
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset_n`  in  1  reset, synchronous and active-low.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  sequencer can accept a command.
- `cmd_op`  in  3  opcode, forwarded unchanged to `INS`.
- `cmd_a`  in  8  operand loaded into DR.
- `cmd_b`  in  8  operand loaded into MQ.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_data`  out  16  result, {Acc, MQ}.
- `rsp_err`  out  1  operation timed out.
- `INS`  out  3  datapath instruction.
- `LDAcc`, `LDMQ`, `LDDR`  out  1 each  datapath load strobes.
- `STAcc`, `STMQ`, `STDR`  out  1 each  datapath store strobes.
- `TESTMODE`  out  1  constant 0.
- `inBUS`  out  8  datapath write bus.
- `outBUS`  in  8  datapath read bus.
- `RDY`  in  1  datapath ready.

## Operation
- **Output decoding:** all datapath controls are registered Moore outputs decoded from the state. Any control not listed for a state is 0; `inBUS` is 0 unless stated.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid`: latch op/a/b, go to LD_DR.
- **LD_DR:** `LDDR`=1, `inBUS`=a. Go to LD_MQ.
- **LD_MQ:** `LDMQ`=1, `inBUS`=b. Go to CLR_ACC.
- **CLR_ACC:** `LDAcc`=1, `inBUS`=0x00. Go to EXEC.
- **EXEC**
  - `INS`=op, held stable for the whole state.
  - `RDY` is ignored in the first EXEC cycle, because it still reflects the previous datapath state.
  - From the second cycle on, `RDY`=1 moves to RD_ACC.
- **RD_ACC:** `STAcc`=1. Capture `outBUS` into `rsp_data[15:8]` at the end of the cycle. Go to RD_MQ.
- **RD_MQ:** `STMQ`=1. Capture `outBUS` into `rsp_data[7:0]`. Go to RESP.
- **RESP**
  - `rsp_valid`=1; `rsp_data` and `rsp_err` are held stable.
  - On `rsp_ready`, go to IDLE.
- **Store strobes:** at most one ST strobe is ever high. `STDR` is never asserted.
- **Busy behaviour:** `cmd_ready`=0 outside IDLE. A command offered while busy is not consumed. There is no same-cycle response-to-command bypass.
- **Reset:**
  - While `reset_n`=0 at an edge: state goes to IDLE, and every output goes to 0, including `cmd_ready`, `rsp_data` and `rsp_err`.
  - `cmd_ready` rises in the cycle after the first edge with `reset_n`=1.
  - Reset during any state discards the in-flight command; no response is produced.

## Timing
- Command accepted at edge T. Then:
  - LD_DR during T+1, LD_MQ during T+2, CLR_ACC during T+3.
  - EXEC begins at T+4.
- Minimum EXEC length is 2 cycles.
- Minimum latency from accept to `rsp_valid` is 8 cycles (RDY seen in the second EXEC cycle).
- Back-to-back throughput is one command per 9 cycles, with `rsp_ready` tied high.

## Configuration
- **`MUL_SEQ_TIMEOUT_EN` defined:**
  - A `TW`-bit counter clears on EXEC entry and increments every EXEC cycle.
  - If the count reaches `TIMEOUT_CYCLES` without qualified `RDY`, go directly to RESP with `rsp_err`=1 and `rsp_data`=0x0000.
  - RD_ACC and RD_MQ are skipped in that case.
  - If `RDY` arrives in the same cycle the limit is reached, `RDY` wins.
- **Undefined:** no counter; EXEC waits indefinitely; `rsp_err` is constant 0.

## Structure
- Package `mul_seq_pkg` holds:
  - the state enum (IDLE, LD_DR, LD_MQ, CLR_ACC, EXEC, RD_ACC, RD_MQ, RESP);
  - the default `TIMEOUT_CYCLES` constant;
  - the 16-bit result typedef.
- Sub-module `mul_seq_watchdog` (clear, enable, limit → expired) is instantiated only under `MUL_SEQ_TIMEOUT_EN`.

## Test plan
- **Basic multiply:** cmd op=3'b101, a=0x05, b=0x03. Model `RDY` on the 3rd EXEC cycle, `outBUS`=0x00 during RD_ACC and 0x0F during RD_MQ.
  - → `LDDR`/`inBUS`=0x05 at T+1, `LDMQ`/0x03 at T+2, `LDAcc`/0x00 at T+3.
  - → `rsp_data`=0x000F, `rsp_err`=0.
- **Early RDY:** `RDY` held 1 throughout → EXEC lasts exactly 2 cycles; `rsp_valid` at T+8.
- **Backpressure:** `rsp_ready`=0 for 5 cycles in RESP.
  - → `rsp_valid` and `rsp_data` stable; `cmd_ready`=0.
  - → A second `cmd_valid` is not accepted until the cycle after the `rsp_ready` handshake.
- **Timeout** (`MUL_SEQ_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8, `RDY`=0) → RESP after 8 EXEC cycles; `rsp_err`=1, `rsp_data`=0x0000; `STAcc`/`STMQ` never asserted.
- **Reset mid-EXEC:** `reset_n`=0 for 1 edge.
  - → All outputs 0 and `INS`=0 next cycle; no `rsp_valid`.
  - → `cmd_ready`=1 the cycle after release.
